// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the SCPU fetch stage: next-PC selects, fetch FSM states,
// reset PC default and the branch-offset helper.
package fetch_unit_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } fetch_state_e;

  // Sign-extended word offset of an I-type branch, in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection for the held instruction.
// The result is raw: alignment handling is left to the fetch_unit top.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: begin
        if (branch && zero) npc = pc_plus4 + branch_offset(instr[15:0]);
        else                npc = pc_plus4;
      end
      NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JR:     npc = rs_data;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// SCPU instruction-fetch stage: PC register, im_req/im_ready fetch handshake and next-PC update.
// Define FETCH_MISALIGN_EXC_EN to redirect misaligned targets to EXC_VECTOR with an exc_misalign pulse.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        advance,
  output logic        exc_misalign,
  output logic [1:0]  state
);

`ifdef FETCH_MISALIGN_EXC_EN
  localparam bit MISALIGN_EXC = 1'b1;
`else
  localparam bit MISALIGN_EXC = 1'b0;
`endif

  // Handshake: a fetch transfers on the rising edge where im_req && im_ready;
  // im_req and im_addr stay stable until then, and im_ready is ignored while im_req is low.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic         exc_q, exc_d;
  logic [31:0]  npc;
  logic         misaligned;

  npc_calc u_npc_calc (
    .pc      (pc_q),
    .instr   (instr_q),
    .npc_op  (npc_op),
    .branch  (branch),
    .zero    (zero),
    .rs_data (rs_data),
    .npc     (npc)
  );

  assign misaligned = (npc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    exc_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (im_ready) begin
          instr_d = im_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (advance) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
          // Without the exception feature a misaligned target is silently truncated.
          if (MISALIGN_EXC && misaligned) begin
            pc_d  = EXC_VECTOR;
            exc_d = 1'b1;
          end else begin
            pc_d  = {npc[31:2], 2'b00};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign im_req       = req_q;
  assign im_addr      = pc_q;
  assign instr        = instr_q;
  assign op           = instr_q[31:26];
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign exc_misalign = exc_q;
  assign state        = state_q;

endmodule
